// File: rtl/xing_pkg.sv
// rtl/xing_pkg.sv - state codes, default timing and lamp decode for the crossing scheduler
package xing_pkg;

  typedef enum logic [3:0] {
    HWY_GREEN   = 4'd0,
    HWY_YELLOW  = 4'd1,
    ALL_RED1    = 4'd2,
    WALK        = 4'd3,
    FLASH_DNW   = 4'd4,
    SIDE_GREEN  = 4'd5,
    SIDE_YELLOW = 4'd6,
    ALL_RED2    = 4'd7,
    EMERGENCY   = 4'd8
  } state_t;

  localparam int T_GREEN_MIN_DEF  = 20;
  localparam int T_YELLOW_DEF     = 4;
  localparam int T_ALLRED_DEF     = 2;
  localparam int T_WALK_DEF       = 10;
  localparam int T_FLASH_DEF      = 6;
  localparam int T_SIDE_GREEN_DEF = 12;

  localparam logic GRANT_CAR = 1'b0;
  localparam logic GRANT_PED = 1'b1;

  typedef struct packed {
    logic hgl, hyl, hrl;
    logic sgl, syl, srl;
    logic hw, hdnw;
  } lamps_t;

  // Anything that is not an explicit go-phase shows red on both roads.
  function automatic lamps_t decode_lamps(input state_t st, input logic flash);
    lamps_t l;
    l = '0;
    l.hrl = 1'b1;
    l.srl = 1'b1;
    l.hdnw = 1'b1;
    case (st)
      HWY_GREEN:   begin l.hrl = 1'b0; l.hgl = 1'b1; end
      HWY_YELLOW:  begin l.hrl = 1'b0; l.hyl = 1'b1; end
      WALK:        begin l.hw = 1'b1; l.hdnw = 1'b0; end
      FLASH_DNW:   l.hdnw = flash;
      SIDE_GREEN:  begin l.srl = 1'b0; l.sgl = 1'b1; end
      SIDE_YELLOW: begin l.srl = 1'b0; l.syl = 1'b1; end
      default:     ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/xing_phase_scheduler_phase_dwell_timer.sv
// rtl/xing_phase_scheduler_phase_dwell_timer.sv - tick-driven dwell counter with optional saturation
module phase_dwell_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             clr,
  input  logic             sat_en,
  input  logic [CNT_W-1:0] limit,
  output logic             done,
  output logic             at_limit
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt;

  assign at_limit = (cnt == limit - ONE);
  assign done     = tick & at_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (tick && !(sat_en && at_limit)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/xing_phase_scheduler.sv
// rtl/xing_phase_scheduler.sv - timed highway/crosswalk/side-street phase scheduler
module xing_phase_scheduler
  import xing_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int T_GREEN_MIN  = T_GREEN_MIN_DEF,
  parameter int T_YELLOW     = T_YELLOW_DEF,
  parameter int T_ALLRED     = T_ALLRED_DEF,
  parameter int T_WALK       = T_WALK_DEF,
  parameter int T_FLASH      = T_FLASH_DEF,
  parameter int T_SIDE_GREEN = T_SIDE_GREEN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       yp,
  input  logic       ns,
  input  logic       emg,
  output logic       hgl,
  output logic       hyl,
  output logic       hrl,
  output logic       sgl,
  output logic       syl,
  output logic       srl,
  output logic       hw,
  output logic       hdnw,
  output logic       ped_wait,
  output logic [3:0] state
);

  state_t           st, st_nxt;
  logic             ped_req, car_req, grant, last, flash, flash_nxt;
  logic [CNT_W-1:0] limit;
  logic             done, at_limit, clr, sat_en;
  logic             enter_walk, enter_side, to_yellow;
  lamps_t           lamps;

  always_comb begin
    limit = CNT_W'(1);
    case (st)
      HWY_GREEN:             limit = CNT_W'(T_GREEN_MIN);
      HWY_YELLOW,
      SIDE_YELLOW:           limit = CNT_W'(T_YELLOW);
      ALL_RED1, ALL_RED2:    limit = CNT_W'(T_ALLRED);
      WALK:                  limit = CNT_W'(T_WALK);
      FLASH_DNW:             limit = CNT_W'(T_FLASH);
      SIDE_GREEN:            limit = CNT_W'(T_SIDE_GREEN);
      default:               limit = CNT_W'(1);
    endcase
  end

  always_comb begin
    st_nxt = st;
    if (emg) begin
      st_nxt = EMERGENCY;
    end else begin
      case (st)
        HWY_GREEN:   if (done && (ped_req || car_req)) st_nxt = HWY_YELLOW;
        HWY_YELLOW:  if (done) st_nxt = ALL_RED1;
        ALL_RED1:    if (done) st_nxt = (grant == GRANT_PED) ? WALK : SIDE_GREEN;
        WALK:        if (done) st_nxt = FLASH_DNW;
        FLASH_DNW:   if (done) st_nxt = ALL_RED2;
        SIDE_GREEN:  if (done) st_nxt = SIDE_YELLOW;
        SIDE_YELLOW: if (done) st_nxt = ALL_RED2;
        ALL_RED2:    if (done) st_nxt = HWY_GREEN;
        default:     st_nxt = ALL_RED2;
      endcase
    end
  end

  assign clr        = (st_nxt != st);
  assign sat_en     = (st == HWY_GREEN);
  assign enter_walk = (st_nxt == WALK) && (st != WALK);
  assign enter_side = (st_nxt == SIDE_GREEN) && (st != SIDE_GREEN);
  assign to_yellow  = (st == HWY_GREEN) && (st_nxt == HWY_YELLOW);

  always_comb begin
    flash_nxt = flash;
    if (st_nxt == FLASH_DNW && st != FLASH_DNW) flash_nxt = 1'b1;
    else if (st == FLASH_DNW && tick)           flash_nxt = ~flash;
  end

  phase_dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .clr      (clr),
    .sat_en   (sat_en),
    .limit    (limit),
    .done     (done),
    .at_limit (at_limit)
  );

  // Lamps are registered from the next-state decode so they change with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= HWY_GREEN;
      ped_req <= 1'b0;
      car_req <= 1'b0;
      grant   <= GRANT_CAR;
      last    <= GRANT_CAR;
      flash   <= 1'b1;
      lamps   <= decode_lamps(HWY_GREEN, 1'b1);
    end else begin
      st      <= st_nxt;
      flash   <= flash_nxt;
      lamps   <= decode_lamps(st_nxt, flash_nxt);
      ped_req <= yp | (ped_req & ~enter_walk);
      car_req <= ns | (car_req & ~enter_side);
      if (to_yellow) begin
        if (ped_req && car_req) grant <= ~last;
        else                    grant <= ped_req ? GRANT_PED : GRANT_CAR;
      end
      if (enter_walk) last <= GRANT_PED;
      if (enter_side) last <= GRANT_CAR;
    end
  end

  assign {hgl, hyl, hrl, sgl, syl, srl, hw, hdnw} = lamps;
  assign ped_wait = ped_req;
  assign state    = st;

endmodule

// File: tb/tb_xing_phase_scheduler.sv
// tb/tb_xing_phase_scheduler.sv - self-checking bench for xing_phase_scheduler
module tb_xing_phase_scheduler;

  localparam int TG = 20, TY = 4, TA = 2, TW = 10, TF = 6, TS = 12;

  logic clk, rst, tick, yp, ns, emg;
  logic hgl, hyl, hrl, sgl, syl, srl, hw, hdnw, ped_wait;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  int m_state, m_remain;
  bit m_ped, m_car, m_grant, m_last, m_flash;

  xing_phase_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick), .yp(yp), .ns(ns), .emg(emg),
    .hgl(hgl), .hyl(hyl), .hrl(hrl), .sgl(sgl), .syl(syl), .srl(srl),
    .hw(hw), .hdnw(hdnw), .ped_wait(ped_wait), .state(state)
  );

  always #5 clk = ~clk;

  function automatic int t_of(input int s);
    case (s)
      0: return TG;
      1, 6: return TY;
      2, 7: return TA;
      3: return TW;
      4: return TF;
      5: return TS;
      default: return 1;
    endcase
  endfunction

  function automatic logic [12:0] dut_vec();
    return {state, hgl, hyl, hrl, sgl, syl, srl, hw, hdnw, ped_wait};
  endfunction

  function automatic logic [12:0] mdl_vec();
    logic [2:0] h, sd;
    logic w, d;
    h  = (m_state == 0) ? 3'b100 : (m_state == 1) ? 3'b010 : 3'b001;
    sd = (m_state == 5) ? 3'b100 : (m_state == 6) ? 3'b010 : 3'b001;
    w  = (m_state == 3);
    d  = (m_state == 4) ? m_flash : (m_state != 3);
    return {m_state[3:0], h, sd, w, d, m_ped};
  endfunction

  task automatic model_reset();
    m_state = 0; m_remain = TG; m_ped = 0; m_car = 0;
    m_grant = 0; m_last = 0; m_flash = 1;
  endtask

  // Phase model: remaining-ticks countdown per phase, transitions from the phase table.
  task automatic model_step(input bit t, input bit y, input bit n, input bit e);
    int nx;
    bit over, ew, es;
    over = t && (m_remain == 1);
    nx = m_state;
    if (e) nx = 8;
    else case (m_state)
      0: if (over && (m_ped || m_car)) nx = 1;
      1: if (over) nx = 2;
      2: if (over) nx = m_grant ? 3 : 5;
      3: if (over) nx = 4;
      4: if (over) nx = 7;
      5: if (over) nx = 6;
      6: if (over) nx = 7;
      7: if (over) nx = 0;
      default: nx = 7;
    endcase
    ew = (nx == 3) && (m_state != 3);
    es = (nx == 5) && (m_state != 5);
    if (m_state == 0 && nx == 1) m_grant = (m_ped && m_car) ? !m_last : m_ped;
    if (ew) m_last = 1;
    if (es) m_last = 0;
    if (nx == 4 && m_state != 4) m_flash = 1;
    else if (m_state == 4 && t) m_flash = !m_flash;
    m_ped = y || (m_ped && !ew);
    m_car = n || (m_car && !es);
    if (nx != m_state) m_remain = t_of(nx);
    else if (t && m_remain > 1) m_remain--;
    m_state = nx;
  endtask

  task automatic step(input bit t, input bit y, input bit n, input bit e);
    tick = t; yp = y; ns = n; emg = e;
    @(posedge clk);
    model_step(t, y, n, e);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; tick = 0; yp = 0; ns = 0; emg = 0;
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (dut_vec() !== 13'b0000_100_001_01_0) begin
      n_fail++; $display("FAIL reset_state got=%b exp=%b", dut_vec(), 13'b0000_100_001_01_0);
    end
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      step(1, 0, 0, 0);
      n_tests++;
      if (state !== 4'd0 || hgl !== 1'b1 || hdnw !== 1'b1 || srl !== 1'b1) begin
        n_fail++; $display("FAIL idle_green cyc=%0d got=%b exp state0/hgl/srl/hdnw", i, dut_vec());
      end
    end
  endtask

  task automatic test_ped_cycle();
    int walk_n, fi;
    logic [5:0] fpat;
    bit seen_walk;
    walk_n = 0; fi = 0; fpat = '0; seen_walk = 0;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      step(1, (i == 5), 0, 0);
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL ped_cycle cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
      end
      if (i == 5) begin
        n_tests++;
        if (ped_wait !== 1'b1) begin n_fail++; $display("FAIL ped_wait_set got=%b exp=1", ped_wait); end
      end
      if (state == 4'd3 && !seen_walk) begin
        seen_walk = 1;
        n_tests++;
        if (ped_wait !== 1'b0) begin n_fail++; $display("FAIL ped_wait_clear got=%b exp=0", ped_wait); end
      end
      if (hw) walk_n++;
      if (state == 4'd4 && fi < 6) begin fpat[5-fi] = hdnw; fi++; end
    end
    n_tests++;
    if (walk_n != TW) begin n_fail++; $display("FAIL walk_len got=%0d exp=%0d", walk_n, TW); end
    n_tests++;
    if (fpat !== 6'b101010) begin n_fail++; $display("FAIL flash_pattern got=%b exp=101010", fpat); end
  endtask

  task automatic test_both_requests();
    int served[$];
    int prev;
    do_reset();
    prev = 0;
    for (int i = 0; i < 200 && served.size() < 2; i++) begin
      step(1, (i == 3), (i == 3), 0);
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL both_req cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
      end
      if ((state == 4'd3 || state == 4'd5) && int'(state) != prev) served.push_back(int'(state));
      prev = int'(state);
    end
    n_tests++;
    if (served.size() != 2 || served[0] != 3 || served[1] != 5) begin
      n_fail++; $display("FAIL both_order got_n=%0d exp walk then side", served.size());
    end
  endtask

  task automatic test_tick_div();
    int side_n, sides, walks, prev;
    side_n = 0; sides = 0; walks = 0; prev = 0;
    do_reset();
    for (int i = 0; i < 2000 && sides < 2; i++) begin
      step((i % 4) == 3, 0, 1, 0);
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL tick_div cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
      end
      if (state == 4'd5 && prev != 5) sides++;
      if (state == 4'd3) walks++;
      if (sides == 1 && sgl) side_n++;
      prev = int'(state);
    end
    n_tests++;
    if (side_n != 48) begin n_fail++; $display("FAIL side_len got=%0d exp=48", side_n); end
    n_tests++;
    if (sides != 2 || walks != 0) begin
      n_fail++; $display("FAIL car_reserve got_sides=%0d walks=%0d exp 2/0", sides, walks);
    end
  endtask

  task automatic test_emergency();
    int guard, ar_n, g_n;
    do_reset();
    guard = 0;
    step(1, 1, 0, 0);
    while (state != 4'd3 && guard < 100) begin step(1, 0, 0, 0); guard++; end
    n_tests++;
    if (state != 4'd3) begin n_fail++; $display("FAIL emg_reach_walk got=%0d exp=3", state); end
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    n_tests++;
    if (state !== 4'd8 || hw !== 1'b0 || hdnw !== 1'b1) begin
      n_fail++; $display("FAIL emg_enter got=%b exp state8 hw0 hdnw1", dut_vec());
    end
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1);
    ar_n = 0; guard = 0;
    step(1, 1, 0, 0);
    while (state != 4'd0 && guard < 50) begin ar_n++; step(1, 1, 0, 0); guard++; end
    n_tests++;
    if (ar_n != TA) begin n_fail++; $display("FAIL emg_allred got=%0d exp=%0d", ar_n, TA); end
    g_n = 0; guard = 0;
    while (hgl && guard < 100) begin
      g_n++;
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL emg_green got=%b exp=%b", dut_vec(), mdl_vec());
      end
      step(1, 1, 0, 0); guard++;
    end
    n_tests++;
    if (g_n != TG) begin n_fail++; $display("FAIL emg_min_green got=%0d exp=%0d", g_n, TG); end
  endtask

  task automatic test_async_reset();
    int guard;
    do_reset();
    guard = 0;
    step(1, 0, 1, 0);
    while (state != 4'd5 && guard < 100) begin step(1, 1, 1, 0); guard++; end
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    n_tests++;
    if (state != 4'd5) begin n_fail++; $display("FAIL arst_reach_side got=%0d exp=5", state); end
    #2 rst = 1;
    #1;
    n_tests++;
    if (dut_vec() !== 13'b0000_100_001_01_0 || dut.car_req !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got=%b car=%b exp=%b car=0", dut_vec(), dut.car_req,
                         13'b0000_100_001_01_0);
    end
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic test_random();
    bit el;
    do_reset();
    el = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39) == 0) el = !el;
      step($urandom_range(1) == 1, $urandom_range(14) == 0, $urandom_range(14) == 0, el);
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL random cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  initial begin
    clk = 0; rst = 1; tick = 0; yp = 0; ns = 0; emg = 0;
    model_reset();
    test_reset();
    test_idle();
    test_ped_cycle();
    test_both_requests();
    test_tick_div();
    test_emergency();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
